// File: rtl/axis_keep_compactor_if.sv
// AXI-Stream bundle with per-byte keep and per-byte user field.
//   data  : payload, data_width bits (N = data_width/8 bytes)
//   keep  : byte enables, N bits
//   user  : per-byte user field, N*user_width_foreach_byte bits
//   last  : end of packet
//   valid/ready : handshake
// master drives everything but ready; slave drives ready.
interface axis_keep_compactor_if #(
  parameter int data_width              = 64,
  parameter int user_width_foreach_byte = 1
);
  localparam int N = data_width / 8;

  logic [data_width-1:0]                data;
  logic [N-1:0]                         keep;
  logic [N*user_width_foreach_byte-1:0] user;
  logic                                 last;
  logic                                 valid;
  logic                                 ready;

  modport master (output data, keep, user, last, valid, input  ready);
  modport slave  (input  data, keep, user, last, valid, output ready);
endinterface

// File: rtl/axis_keep_compactor.sv
// Keep compactor: drops every input byte whose keep bit is 0 and repacks the
// survivors (with their user bits) into dense output beats of the same width.
// Output keep is all ones, except on the last beat of a packet where it is
// low-contiguous (possibly zero for an empty packet).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   s_axis     : sparse-keep input stream (slave)
//   m_axis     : dense output stream (master), driven from registers
// A 2N-byte buffer holds pending bytes; slots 0..N-1 are the output beat.

// One buffer slot: next value is either the (possibly shifted) old content
// or the input byte whose compacted position lands on this slot.
module akc_slot #(
  parameter int N   = 8,
  parameter int UW  = 1,
  parameter int CW  = 5,
  parameter int IDX = 0
) (
  input  logic [7:0]              sh_byte_i,
  input  logic [UW-1:0]           sh_usr_i,
  input  logic [N-1:0][7:0]       in_byte_i,
  input  logic [N-1:0][UW-1:0]    in_usr_i,
  input  logic [N-1:0]            keep_i,
  input  logic [N-1:0][CW-1:0]    pos_i,
  input  logic [CW-1:0]           base_i,
  input  logic                    wr_i,
  output logic [7:0]              byte_o,
  output logic [UW-1:0]           usr_o
);
  always_comb begin
    byte_o = sh_byte_i;
    usr_o  = sh_usr_i;
    for (int j = 0; j < N; j++) begin
      if (wr_i && keep_i[j] && ((base_i + pos_i[j]) == CW'(IDX))) begin
        byte_o = in_byte_i[j];
        usr_o  = in_usr_i[j];
      end
    end
  end
endmodule

module axis_keep_compactor #(
  parameter int data_width              = 64,
  parameter int user_width_foreach_byte = 1,
  parameter int simulation_delay        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis_keep_compactor_if.slave  s_axis,
  axis_keep_compactor_if.master m_axis
);
  localparam int N  = data_width / 8;
  localparam int UW = user_width_foreach_byte;
  localparam int NB = 2 * N;
  localparam int CW = $clog2(NB) + 1;

  if ((data_width % 8) != 0 || user_width_foreach_byte < 1 || simulation_delay < 0) begin : g_bad_param
    $error("axis_keep_compactor: illegal parameter set");
  end

  logic [NB-1:0][7:0]    byte_q, byte_d;
  logic [NB-1:0][UW-1:0] usr_q, usr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_pend_q, last_pend_d;

  logic [N-1:0][7:0]     in_byte;
  logic [N-1:0][UW-1:0]  in_usr;
  logic [N-1:0][CW-1:0]  pos;
  logic [CW-1:0]         in_n, out_n, base;
  logic                  full, m_last, out_hs, in_hs;

  assign in_byte = s_axis.data;
  assign in_usr  = s_axis.user;

  // Output side is a pure decode of registered state.
  assign full          = cnt_q >= CW'(N);
  assign m_last        = last_pend_q && (cnt_q <= CW'(N));
  assign m_axis.valid  = full || last_pend_q;
  assign m_axis.last   = m_last;
  assign m_axis.data   = byte_q[N-1:0];
  assign m_axis.user   = usr_q[N-1:0];
  for (genvar i = 0; i < N; i++) begin : g_keep
    assign m_axis.keep[i] = cnt_q > CW'(i);
  end

  // Room exists if the buffer is under one beat, or a full beat leaves now.
  // Holding off while last_pend keeps packets from merging in the buffer.
  assign s_axis.ready = !last_pend_q && (!full || m_axis.ready);

  assign out_hs = m_axis.valid && m_axis.ready;
  assign in_hs  = s_axis.valid && s_axis.ready;
  assign out_n  = !out_hs ? '0 : (full ? CW'(N) : cnt_q);
  assign base   = cnt_q - out_n;

  // pos[j] = number of kept bytes below index j (compacted offset of byte j).
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int j = 0; j < N; j++) begin
      pos[j] = acc;
      acc    = acc + CW'(s_axis.keep[j]);
    end
    in_n = acc;
  end

  // Shift by N on output, then append compacted input at base.
  for (genvar g = 0; g < NB; g++) begin : g_slot
    logic [7:0]    sh_byte;
    logic [UW-1:0] sh_usr;
    if (g < N) begin : g_lo
      assign sh_byte = out_hs ? byte_q[g+N] : byte_q[g];
      assign sh_usr  = out_hs ? usr_q[g+N]  : usr_q[g];
    end else begin : g_hi
      assign sh_byte = out_hs ? '0 : byte_q[g];
      assign sh_usr  = out_hs ? '0 : usr_q[g];
    end
    akc_slot #(.N(N), .UW(UW), .CW(CW), .IDX(g)) u_slot (
      .sh_byte_i (sh_byte),
      .sh_usr_i  (sh_usr),
      .in_byte_i (in_byte),
      .in_usr_i  (in_usr),
      .keep_i    (s_axis.keep),
      .pos_i     (pos),
      .base_i    (base),
      .wr_i      (in_hs),
      .byte_o    (byte_d[g]),
      .usr_o     (usr_d[g])
    );
  end

  always_comb begin
    cnt_d       = base + (in_hs ? in_n : '0);
    last_pend_d = last_pend_q;
    if (out_hs && m_last)      last_pend_d = 1'b0;
    if (in_hs && s_axis.last)  last_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q      <= '0;
      usr_q       <= '0;
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
    end else begin
      byte_q      <= byte_d;
      usr_q       <= usr_d;
      cnt_q       <= cnt_d;
      last_pend_q <= last_pend_d;
    end
  end
endmodule
